// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rf_pkg
//  Description : Shared register-file constants and the write-entry type used
//                by writeback producers and the register write buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;

   // Register 0 is hard-wired; writes to it are dropped and lookups never hit.
   localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] idx;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/reg_write_buffer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : reg_write_buffer_if
//  Description : Producer enqueue handshake, register-file write port and the
//                two bypass lookup channels of the register write buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_buffer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] in_reg;
   logic [DATA_W-1:0] in_data;
   logic              rf_busy;
   logic              rf_regWrite;
   logic [ADDR_W-1:0] rf_writeReg;
   logic [DATA_W-1:0] rf_writeData;
   logic [ADDR_W-1:0] byp_rs;
   logic [ADDR_W-1:0] byp_rt;
   logic              byp1_hit;
   logic [DATA_W-1:0] byp1_data;
   logic              byp2_hit;
   logic [DATA_W-1:0] byp2_data;
   logic [CNT_W-1:0]  count;

   // Environment side: producers, register file and read-port consumers.
   modport master (
      output in_valid, in_reg, in_data, rf_busy, byp_rs, byp_rt,
      input  in_ready, rf_regWrite, rf_writeReg, rf_writeData,
             byp1_hit, byp1_data, byp2_hit, byp2_data, count
   );

   // Buffer side.
   modport slave (
      input  in_valid, in_reg, in_data, rf_busy, byp_rs, byp_rt,
      output in_ready, rf_regWrite, rf_writeReg, rf_writeData,
             byp1_hit, byp1_data, byp2_hit, byp2_data, count
   );

endinterface
`default_nettype wire

// File: rtl/byp_match_sel.sv
`default_nettype none
// ============================================================================
//  Module      : byp_match_sel
//  Description : Searches the occupied queue entries for a register index and
//                returns a hit flag plus the data of the youngest match.
//  Revision    : 1.0 - initial release
// ============================================================================
module byp_match_sel
   import rf_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wire logic [DEPTH-1:0]           occ,
   input  var  rf_wr_entry_t               entries [DEPTH],
   input  wire logic [$clog2(DEPTH)-1:0]   head,
   input  wire logic [RF_ADDR_W-1:0]       addr,
   output logic                            hit,
   output logic [RF_DATA_W-1:0]            data
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] slot;

   // Walk oldest to youngest from head; later matches override earlier ones.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      slot = '0;
      for (int k = 0; k < DEPTH; k++) begin
         slot = head + PTR_W'(k);
         if (addr != REG_ZERO && occ[slot] && entries[slot].idx == addr) begin
            hit  = 1'b1;
            data = entries[slot].data;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/reg_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_buffer
//  Description : Circular queue of pending register writes drained one per
//                cycle into the register file write port when it is free,
//                with combinational bypass lookups for the rs/rt read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_buffer
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   reg_write_buffer_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   rf_wr_entry_t     entries_q [DEPTH];
   rf_wr_entry_t     entries_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             nonempty;
   logic             push;
   logic             pop;
   logic [DEPTH-1:0] occ;
   logic [PTR_W-1:0] offs;

   assign nonempty = (count_q != '0);

   // Full blocks acceptance even when a pop is happening this cycle.
   assign bus.in_ready = (count_q < CNT_W'(DEPTH));

   // Writes to register 0 complete the handshake but are never stored.
   assign push = bus.in_valid && bus.in_ready && (RF_ADDR_W'(bus.in_reg) != REG_ZERO);

   // The head is presented whenever something is queued; it commits only when
   // the main datapath is not using the write port.
   assign pop              = nonempty && !bus.rf_busy;
   assign bus.rf_regWrite  = pop;
   assign bus.rf_writeReg  = nonempty ? ADDR_W'(entries_q[head_q].idx)  : '0;
   assign bus.rf_writeData = nonempty ? DATA_W'(entries_q[head_q].data) : '0;
   assign bus.count        = count_q;

   // Slot i is occupied when its distance from head is below the count.
   always_comb begin
      occ  = '0;
      offs = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs   = PTR_W'(i) - head_q;
         occ[i] = (CNT_W'(offs) < count_q);
      end
   end

   // Next-state for storage, pointers and occupancy count.
   always_comb begin
      entries_d = entries_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      if (push) begin
         entries_d[tail_q].idx  = RF_ADDR_W'(bus.in_reg);
         entries_d[tail_q].data = RF_DATA_W'(bus.in_data);
         tail_d                 = tail_q + 1'b1;
      end
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Queue state; reset discards anything still pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entries_q <= entries_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
      end
   end

   byp_match_sel #(.DEPTH(DEPTH)) u_byp_rs (
      .occ     (occ),
      .entries (entries_q),
      .head    (head_q),
      .addr    (RF_ADDR_W'(bus.byp_rs)),
      .hit     (bus.byp1_hit),
      .data    (bus.byp1_data)
   );

   byp_match_sel #(.DEPTH(DEPTH)) u_byp_rt (
      .occ     (occ),
      .entries (entries_q),
      .head    (head_q),
      .addr    (RF_ADDR_W'(bus.byp_rt)),
      .hit     (bus.byp2_hit),
      .data    (bus.byp2_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_reg_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_buffer
//  Description : Directed and randomized bench for reg_write_buffer, checked
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_buffer;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   reg_write_buffer_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) bus ();

   reg_write_buffer #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Youngest queued write to a nonzero register, if any.
   function automatic void byp_ref(input logic [4:0] a, output logic h, output logic [31:0] d);
      h = 1'b0;
      d = '0;
      if (a != 0) begin
         for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].r == a) begin
               h = 1'b1;
               d = mq[i].d;
               break;
            end
         end
      end
   endfunction

   task automatic check_outputs();
      logic        h1, h2;
      logic [31:0] d1, d2;
      int          n;
      n = mq.size();
      byp_ref(bus.byp_rs, h1, d1);
      byp_ref(bus.byp_rt, h2, d2);
      check_val("count",     64'(bus.count),        64'(n));
      check_val("in_ready",  64'(bus.in_ready),     64'(n < DEPTH));
      check_val("regWrite",  64'(bus.rf_regWrite),  64'(n != 0 && !bus.rf_busy));
      check_val("writeReg",  64'(bus.rf_writeReg),  64'(n != 0 ? mq[0].r : 5'd0));
      check_val("writeData", 64'(bus.rf_writeData), 64'(n != 0 ? mq[0].d : 32'd0));
      check_val("byp1_hit",  64'(bus.byp1_hit),     64'(h1));
      check_val("byp1_data", 64'(bus.byp1_data),    64'(d1));
      check_val("byp2_hit",  64'(bus.byp2_hit),     64'(h2));
      check_val("byp2_data", 64'(bus.byp2_data),    64'(d2));
   endtask

   // One clock cycle: drive, check combinational outputs, then advance the model.
   task automatic step(input logic v, input logic [4:0] r, input logic [31:0] d,
                       input logic busy, input logic [4:0] rs, input logic [4:0] rt);
      bit ready, we;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_reg   = r;
      bus.in_data  = d;
      bus.rf_busy  = busy;
      bus.byp_rs   = rs;
      bus.byp_rt   = rt;
      #1;
      check_outputs();
      ready = (mq.size() < DEPTH);
      we    = (mq.size() != 0) && !busy;
      @(posedge clk);
      if (we) void'(mq.pop_front());
      if (v && ready && r != 0) mq.push_back('{r, d});
   endtask

   // Reset asserted between edges: outputs must clear without waiting for a clock.
   task automatic mid_reset();
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      mq.delete();
      check_outputs();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_reg   = '0;
      bus.in_data  = '0;
      bus.rf_busy  = 1'b0;
      bus.byp_rs   = '0;
      bus.byp_rt   = '0;

      // Reset state with a nonzero lookup address applied.
      repeat (2) @(negedge clk);
      bus.byp_rs = 5'd5;
      #1;
      check_outputs();
      rst = 1'b0;

      // Single write: presented the cycle after acceptance, then drained.
      step(1, 5'd5, 32'hAAAA0001, 0, 5'd5, 5'd0);
      step(0, 5'd0, 32'h0, 0, 5'd5, 5'd0);
      step(0, 5'd0, 32'h0, 0, 5'd5, 5'd0);

      // Fill while the port is busy; fifth write refused; drain in order.
      step(1, 5'd1, 32'h11, 1, 5'd1, 5'd4);
      step(1, 5'd2, 32'h22, 1, 5'd1, 5'd4);
      step(1, 5'd3, 32'h33, 1, 5'd1, 5'd4);
      step(1, 5'd4, 32'h44, 1, 5'd1, 5'd4);
      step(1, 5'd9, 32'h55, 1, 5'd1, 5'd9);
      for (int i = 0; i < 5; i++) step(0, 5'd0, 32'h0, 0, 5'd3, 5'd4);

      // Youngest of two writes to the same register wins the bypass.
      step(1, 5'd7, 32'h10, 1, 5'd7, 5'd0);
      step(1, 5'd7, 32'h20, 1, 5'd7, 5'd0);
      step(0, 5'd0, 32'h0, 1, 5'd7, 5'd0);
      for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 0, 5'd7, 5'd7);

      // Register-0 write handshakes but is dropped.
      step(1, 5'd0, 32'hDEAD, 0, 5'd0, 5'd0);
      step(0, 5'd0, 32'h0, 0, 5'd0, 5'd0);

      // Steady push+pop at count 2; pointers wrap several times.
      step(1, 5'd10, 32'hA0, 1, 5'd10, 5'd11);
      step(1, 5'd11, 32'hA1, 1, 5'd10, 5'd11);
      for (int i = 0; i < 6; i++)
         step(1, 5'(12 + i), 32'hB0 + 32'(i), 0, 5'(11 + i), 5'(12 + i));
      for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 0, 5'd16, 5'd17);

      // Asynchronous reset with three pending writes.
      step(1, 5'd20, 32'hC0, 1, 5'd20, 5'd22);
      step(1, 5'd21, 32'hC1, 1, 5'd20, 5'd22);
      step(1, 5'd22, 32'hC2, 1, 5'd20, 5'd22);
      mid_reset();
      for (int i = 0; i < 3; i++) step(0, 5'd0, 32'h0, 0, 5'd20, 5'd22);

      // Random traffic over a small register range to exercise bypass hits.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
